mmu_utlb_inst: RTL and testbench

Instruction-side address translation unit with a parametrised, fully associative micro-TLB (uTLB) in front of the shared main-TLB search port. It sits between the fetch stage and the main TLB:
- unmapped kseg0/kseg1 fetches and uTLB hits translate in the same cycle;
- uTLB misses take one extra cycle through the main-TLB search port, then fill the uTLB;
- TLB refill and invalid exceptions are reported alongside the response.

---
 rtl/mmu_utlb_inst_if.sv | 41 ++++
 rtl/mmu_utlb_inst.sv | 119 +++++++++++
 tb/tb_mmu_utlb_inst.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_utlb_inst_if.sv
// Fetch-side translation request/response plus main-TLB search port of the
// instruction micro-TLB, bundled so the fetch stage and TLB connect through one port.
interface mmu_utlb_inst_if #(
  parameter int TLBNUM = 16
);
  localparam int IDX_W = $clog2(TLBNUM);

  logic             req_valid;
  logic [31:0]      req_vaddr;
  logic [7:0]       asid;
  logic             flush;
  logic             resp_valid;
  logic [31:0]      resp_paddr;
  logic             resp_cached;
  logic             resp_refill;
  logic             resp_invalid;
  logic             stall;
  logic [18:0]      s_vpn;
  logic             s_odd;
  logic [7:0]       s_asid;
  logic             s_found;
  logic [IDX_W-1:0] s_index;
  logic [19:0]      s_pfn;
  logic [2:0]       s_c;
  logic             s_d;
  logic             s_v;

  modport slave (
    input  req_valid, req_vaddr, asid, flush,
    input  s_found, s_index, s_pfn, s_c, s_d, s_v,
    output resp_valid, resp_paddr, resp_cached, resp_refill, resp_invalid, stall,
    output s_vpn, s_odd, s_asid
  );

  modport master (
    output req_valid, req_vaddr, asid, flush,
    output s_found, s_index, s_pfn, s_c, s_d, s_v,
    input  resp_valid, resp_paddr, resp_cached, resp_refill, resp_invalid, stall,
    input  s_vpn, s_odd, s_asid
  );
endinterface

// File: rtl/mmu_utlb_inst.sv
// Instruction address translation: direct kseg0/kseg1 mapping, a fully associative
// round-robin micro-TLB, and a one-cycle main-TLB lookup path on a uTLB miss.
module mmu_utlb_inst #(
  parameter int TLBNUM       = 16,
  parameter int UTLB_ENTRIES = 4
) (
  input  logic           clk,
  input  logic           rst,
  mmu_utlb_inst_if.slave bus
);
  localparam int RP_W = $clog2(UTLB_ENTRIES);

  typedef enum logic {IDLE, LOOKUP} state_t;

  state_t                  state_q, state_d;
  logic [UTLB_ENTRIES-1:0] valid_q;
  logic [19:0]             vpn_q [UTLB_ENTRIES];
  logic [19:0]             pfn_q [UTLB_ENTRIES];
  logic [2:0]              c_q   [UTLB_ENTRIES];
  logic [RP_W-1:0]         rp_q;
  logic [7:0]              asid_q;
  logic [31:0]             lk_vaddr_q;

  logic        direct, hit, flush_all, fill_en, start_lk;
  logic [19:0] hit_pfn;
  logic [2:0]  hit_c;
  logic        unused_ok;

  assign unused_ok = ^{bus.s_d, bus.s_index};

  // Entries never hold duplicate VPNs, so OR-merging the matching slot is exact.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_c   = '0;
    for (int i = 0; i < UTLB_ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == bus.req_vaddr[31:12])) begin
        hit     = 1'b1;
        hit_pfn = hit_pfn | pfn_q[i];
        hit_c   = hit_c | c_q[i];
      end
    end
  end

  assign direct    = (bus.req_vaddr[31:30] == 2'b10);
  assign flush_all = bus.flush | (bus.asid != asid_q);
  assign fill_en   = (state_q == LOOKUP) && bus.s_found && bus.s_v && !flush_all;
  assign start_lk  = (state_q == IDLE) && bus.req_valid && !direct && !hit;

  always_comb begin
    state_d          = state_q;
    bus.resp_valid   = 1'b0;
    bus.resp_paddr   = '0;
    bus.resp_cached  = 1'b0;
    bus.resp_refill  = 1'b0;
    bus.resp_invalid = 1'b0;
    bus.stall        = 1'b0;
    bus.s_vpn        = bus.req_vaddr[31:13];
    bus.s_odd        = bus.req_vaddr[12];
    bus.s_asid       = bus.asid;
    if (state_q == LOOKUP) begin
      state_d          = IDLE;
      bus.s_vpn        = lk_vaddr_q[31:13];
      bus.s_odd        = lk_vaddr_q[12];
      bus.resp_valid   = 1'b1;
      bus.resp_refill  = ~bus.s_found;
      bus.resp_invalid = bus.s_found & ~bus.s_v;
      if (bus.s_found && bus.s_v) begin
        bus.resp_paddr  = {bus.s_pfn, lk_vaddr_q[11:0]};
        bus.resp_cached = (bus.s_c == 3'd3);
      end
    end else if (bus.req_valid) begin
      if (direct) begin
        bus.resp_valid  = 1'b1;
        bus.resp_paddr  = {3'b000, bus.req_vaddr[28:0]};
        bus.resp_cached = ~bus.req_vaddr[29];
      end else if (hit) begin
        bus.resp_valid  = 1'b1;
        bus.resp_paddr  = {hit_pfn, bus.req_vaddr[11:0]};
        bus.resp_cached = (hit_c == 3'd3);
      end else begin
        bus.stall = 1'b1;
        state_d   = LOOKUP;
      end
    end
  end

  // Control state; flush wins over a same-edge fill, rp survives flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      rp_q    <= '0;
      asid_q  <= '0;
    end else begin
      state_q <= state_d;
      asid_q  <= bus.asid;
      if (flush_all) begin
        valid_q <= '0;
      end else if (fill_en) begin
        valid_q[rp_q] <= 1'b1;
      end
      if (fill_en) begin
        rp_q <= rp_q + RP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_lk) begin
      lk_vaddr_q <= bus.req_vaddr;
    end
    if (fill_en) begin
      vpn_q[rp_q] <= lk_vaddr_q[31:12];
      pfn_q[rp_q] <= bus.s_pfn;
      c_q[rp_q]   <= bus.s_c;
    end
  end
endmodule

// File: tb/tb_mmu_utlb_inst.sv
// Directed bench for the instruction micro-TLB: a translation model checks every
// output on each falling edge, and literal expectations pin the key scenarios.
module tb_mmu_utlb_inst;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmu_utlb_inst_if #(.TLBNUM(16)) bus ();

  mmu_utlb_inst #(.TLBNUM(16), .UTLB_ENTRIES(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Translation model: a table of cached pages filled round-robin, a pending lookup flag.
  bit          m_ready = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_lk;
  bit          m_v   [N];
  logic [19:0] m_vpn [N];
  logic [19:0] m_pfn [N];
  logic [2:0]  m_c   [N];
  int          m_rp  = 0;
  logic [7:0]  m_asid = 8'h00;

  function automatic bit m_hit(input logic [31:0] va, output logic [19:0] pf, output logic [2:0] c);
    pf = '0;
    c  = '0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_vpn[i] == va[31:12]) begin
        pf = m_pfn[i];
        c  = m_c[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic [19:0] pf;
    logic [2:0]  c;
    bit          fl;
    if (rst) begin
      m_ready = 1'b1;
      m_pend  = 1'b0;
      m_rp    = 0;
      m_asid  = 8'h00;
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    end else if (m_ready) begin
      fl = bus.flush || (bus.asid != m_asid);
      if (m_pend) begin
        if (bus.s_found && bus.s_v && !fl) begin
          m_v[m_rp]   = 1'b1;
          m_vpn[m_rp] = m_lk[31:12];
          m_pfn[m_rp] = bus.s_pfn;
          m_c[m_rp]   = bus.s_c;
          m_rp        = (m_rp + 1) % N;
        end
        m_pend = 1'b0;
      end else if (bus.req_valid && bus.req_vaddr[31:30] != 2'b10 && !m_hit(bus.req_vaddr, pf, c)) begin
        m_pend = 1'b1;
        m_lk   = bus.req_vaddr;
      end
      if (fl) for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_asid = bus.asid;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_pa, va;
    logic        e_rv, e_c, e_rf, e_iv, e_st;
    logic [19:0] pf;
    logic [2:0]  c;
    if (m_ready) begin
      e_pa = 0; e_rv = 0; e_c = 0; e_rf = 0; e_iv = 0; e_st = 0;
      va = m_pend ? m_lk : bus.req_vaddr;
      if (m_pend) begin
        e_rv = 1;
        e_rf = !bus.s_found;
        e_iv = bus.s_found && !bus.s_v;
        if (bus.s_found && bus.s_v) begin
          e_pa = (32'(bus.s_pfn) << 12) + (m_lk & 32'hFFF);
          e_c  = (bus.s_c == 3);
        end
      end else if (bus.req_valid) begin
        if (va[31:30] == 2'b10) begin
          e_rv = 1;
          e_pa = va & 32'h1FFF_FFFF;
          e_c  = (va[29] == 1'b0);
        end else if (m_hit(va, pf, c)) begin
          e_rv = 1;
          e_pa = (32'(pf) << 12) + (va & 32'hFFF);
          e_c  = (c == 3);
        end else begin
          e_st = 1;
        end
      end
      cmp("resp_valid",   32'(bus.resp_valid),   32'(e_rv));
      cmp("resp_paddr",   bus.resp_paddr,        e_pa);
      cmp("resp_cached",  32'(bus.resp_cached),  32'(e_c));
      cmp("resp_refill",  32'(bus.resp_refill),  32'(e_rf));
      cmp("resp_invalid", 32'(bus.resp_invalid), 32'(e_iv));
      cmp("stall",        32'(bus.stall),        32'(e_st));
      cmp("s_vpn",        32'(bus.s_vpn),        va >> 13);
      cmp("s_odd",        32'(bus.s_odd),        32'(va[12]));
      cmp("s_asid",       32'(bus.s_asid),       32'(bus.asid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] va);
    bus.req_valid = 1'b1;
    bus.req_vaddr = va;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 0; bus.req_vaddr = 0; bus.asid = 0; bus.flush = 0;
    bus.s_found = 0; bus.s_index = 0; bus.s_pfn = 0; bus.s_c = 0; bus.s_d = 0; bus.s_v = 0;
    tick(); tick();
    rst = 1'b0;
    #2;
    cmp("rst_rv", 32'(bus.resp_valid), 0);
    cmp("rst_stall", 32'(bus.stall), 0);

    // Direct segments
    tick(); go(32'h8000_1234);
    cmp("kseg0_rv", 32'(bus.resp_valid), 1);
    cmp("kseg0_pa", bus.resp_paddr, 32'h0000_1234);
    cmp("kseg0_c", 32'(bus.resp_cached), 1);
    tick(); go(32'hA000_1234);
    cmp("kseg1_pa", bus.resp_paddr, 32'h0000_1234);
    cmp("kseg1_c", 32'(bus.resp_cached), 0);

    // Miss, fill, then same-cycle hit on the same page
    bus.s_found = 1; bus.s_v = 1; bus.s_pfn = 20'h12345; bus.s_c = 3;
    tick(); go(32'h0040_0010);
    cmp("miss_stall", 32'(bus.stall), 1);
    cmp("miss_rv", 32'(bus.resp_valid), 0);
    tick(); #2;
    cmp("fill_rv", 32'(bus.resp_valid), 1);
    cmp("fill_pa", bus.resp_paddr, 32'h1234_5010);
    cmp("fill_c", 32'(bus.resp_cached), 1);
    cmp("fill_svpn", 32'(bus.s_vpn), 32'h200);
    tick(); bus.s_found = 0; go(32'h0040_0FFC);
    cmp("hit_rv", 32'(bus.resp_valid), 1);
    cmp("hit_pa", bus.resp_paddr, 32'h1234_5FFC);

    // Refill exception, not cached; repeat misses again
    tick(); go(32'h0050_0000);
    tick(); #2;
    cmp("refill", 32'(bus.resp_refill), 1);
    cmp("refill_pa", bus.resp_paddr, 0);
    tick(); #2;
    cmp("refill_again", 32'(bus.stall), 1);
    tick();
    tick(); bus.s_found = 1; bus.s_v = 0; go(32'h0060_0000);
    tick(); #2;
    cmp("invalid", 32'(bus.resp_invalid), 1);
    cmp("invalid_pa", bus.resp_paddr, 0);

    // Round-robin eviction over N+1 pages
    tick(); bus.req_valid = 0; bus.flush = 1;
    tick(); bus.flush = 0; bus.s_v = 1; bus.s_c = 2;
    for (int i = 0; i <= N; i++) begin
      bus.s_pfn = 20'h100 + 20'(i);
      go(32'(i) << 12);
      tick(); tick();
    end
    go(32'h0000_1000);
    cmp("evict_keep_rv", 32'(bus.resp_valid), 1);
    cmp("evict_keep_pa", bus.resp_paddr, 32'h0010_1000);
    cmp("evict_keep_c", 32'(bus.resp_cached), 0);
    tick(); go(32'h0000_0000);
    cmp("evicted_stall", 32'(bus.stall), 1);
    tick(); tick();

    // Flush in the same cycle as a fill
    bus.s_pfn = 20'h0ABCD; go(32'h0070_0000);
    tick(); bus.flush = 1; #2;
    cmp("flushfill_rv", 32'(bus.resp_valid), 1);
    cmp("flushfill_pa", bus.resp_paddr, 32'h0ABC_D000);
    tick(); bus.flush = 0; bus.req_valid = 0;
    tick(); go(32'h0070_0000);
    cmp("flushfill_miss", 32'(bus.stall), 1);
    tick(); tick();

    // ASID change flushes
    bus.req_valid = 0; bus.asid = 8'h01;
    tick(); go(32'h0080_0000);
    tick(); tick(); #0;
    cmp("asid1_hit", 32'(bus.resp_valid), 1);
    bus.req_valid = 0; bus.asid = 8'h02;
    tick(); go(32'h0080_0000);
    cmp("asid2_miss", 32'(bus.stall), 1);
    tick(); #2;
    cmp("asid2_sasid", 32'(bus.s_asid), 32'h02);
    cmp("asid2_svpn", 32'(bus.s_vpn), 32'h400);
    tick();

    // Reset during lookup: no fill
    bus.req_valid = 0;
    tick(); go(32'h0090_0000);
    tick(); rst = 1;
    tick(); rst = 0; #2;
    cmp("rstlk_miss", 32'(bus.stall), 1);
    tick(); tick();

    // req_valid dropped during lookup still fills
    bus.req_valid = 0;
    tick(); go(32'h00A0_0000);
    tick(); bus.req_valid = 0; #2;
    cmp("drop_rv", 32'(bus.resp_valid), 1);
    tick(); go(32'h00A0_0000);
    cmp("drop_hit", 32'(bus.resp_valid), 1);
    cmp("drop_hit_stall", 32'(bus.stall), 0);
    cmp("drop_hit_pa", bus.resp_paddr, 32'h0ABC_D000);

    tick(); bus.req_valid = 0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
